// File: rtl/controlador_sequenciador_param.sv
// SAP controller-sequencer: one-hot T-state ring, early end, HALT latch, jumps.
// Ports: clk/clr, opcode a, flags flag_z/flag_n -> t, datapath controls, n_hlt, halted, instr_done.
module controlador_sequenciador_param #(
  parameter int unsigned T_STATES  = 6,
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned EARLY_END = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [OPCODE_W-1:0] a,
  input  logic                flag_z,
  input  logic                flag_n,
  output logic [T_STATES-1:0] t,
  output logic                cp,
  output logic                ep,
  output logic                eu,
  output logic                su,
  output logic                ea,
  output logic                n_lm,
  output logic                n_ce,
  output logic                n_l1,
  output logic                n_e1,
  output logic                n_la,
  output logic                n_lb,
  output logic                n_l0,
  output logic                n_lp,
  output logic                n_hlt,
  output logic                halted,
  output logic                instr_done
);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0011);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] OP_JN  = OPCODE_W'(4'b0101);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  logic [T_STATES-1:0] t_q, t_d;
  logic                halted_q, halted_d;

  logic is_lda, is_add, is_sub, is_jmp;
  logic is_jz, is_jn, is_out, is_hlt, is_nop;
  logic jmp_take;
  logic mem_op;
  logic last_st;

  // Full-width compare, so wider opcodes with high bits set decode as NOP.
  always_comb begin
    is_lda = 1'b0;
    is_add = 1'b0;
    is_sub = 1'b0;
    is_jmp = 1'b0;
    is_jz  = 1'b0;
    is_jn  = 1'b0;
    is_out = 1'b0;
    is_hlt = 1'b0;
    is_nop = 1'b0;
    case (a)
      OP_LDA:  is_lda = 1'b1;
      OP_ADD:  is_add = 1'b1;
      OP_SUB:  is_sub = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      OP_JZ:   is_jz  = 1'b1;
      OP_JN:   is_jn  = 1'b1;
      OP_OUT:  is_out = 1'b1;
      OP_HLT:  is_hlt = 1'b1;
      default: is_nop = 1'b1;
    endcase
  end

  assign jmp_take = is_jmp | (is_jz & flag_z) | (is_jn & flag_n);
  assign mem_op   = is_lda | is_add | is_sub;

  // Last active T-state of the current instruction (HLT handled apart).
  assign last_st =
      (t_q[3] & (is_out | is_jmp | is_jz | is_jn | is_nop))
    | (t_q[4] & is_lda)
    | (t_q[5] & (is_add | is_sub));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      t_q      <= T_STATES'(1);
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (t_q[3] && is_hlt) begin
        t_d      = '0;
        halted_d = 1'b1;
      end else if ((EARLY_END != 0) && last_st) begin
        t_d = T_STATES'(1);
      end else begin
        t_d = {t_q[T_STATES-2:0], t_q[T_STATES-1]};
      end
    end
  end

  // While halted t is all zeros, so every t-gated control drops out.
  always_comb begin
    ep   = t_q[0];
    cp   = t_q[1];
    eu   = t_q[5] & (is_add | is_sub);
    su   = t_q[5] & is_sub;
    ea   = t_q[3] & is_out;
    n_lm = ~(t_q[0] | (t_q[3] & mem_op));
    n_ce = ~(t_q[2] | (t_q[4] & mem_op));
    n_l1 = ~t_q[2];
    n_e1 = ~(t_q[3] & (mem_op | jmp_take));
    n_la = ~((t_q[4] & is_lda) | (t_q[5] & (is_add | is_sub)));
    n_lb = ~(t_q[4] & (is_add | is_sub));
    n_l0 = ~(t_q[3] & is_out);
    n_lp = ~(t_q[3] & jmp_take);
    n_hlt = ~(halted_q | (t_q[3] & is_hlt));
    if (EARLY_END != 0) begin
      instr_done = last_st | (t_q[3] & is_hlt);
    end else begin
      instr_done = t_q[T_STATES-1] | (t_q[3] & is_hlt);
    end
  end

  assign t      = t_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_controlador_sequenciador_param.sv
// Bench for controlador_sequenciador_param: two instances (6/early, 8/full, 5-bit op)
// checked each cycle against a step-count model plus literal expectations.
module tb_controlador_sequenciador_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic [3:0]  a0;
  logic [4:0]  a1;
  logic        fz, fn;
  logic [5:0]  t0;
  logic [7:0]  t1;
  logic        h0, h1;
  logic [14:0] o0, o1;

  int tests = 0;
  int fails = 0;
  int step[2];
  int cur[2];
  bit hlt[2];
  bit pick[2];
  int q0[$];
  int q1[$];
  int fz_force = -1;
  bit chk_en = 1'b0;

  controlador_sequenciador_param #(
    .T_STATES(6), .OPCODE_W(4), .EARLY_END(1)
  ) dut0 (
    .clk(clk), .clr(clr), .a(a0), .flag_z(fz), .flag_n(fn), .t(t0),
    .cp(o0[14]), .ep(o0[13]), .eu(o0[12]), .su(o0[11]), .ea(o0[10]),
    .n_lm(o0[9]), .n_ce(o0[8]), .n_l1(o0[7]), .n_e1(o0[6]),
    .n_la(o0[5]), .n_lb(o0[4]), .n_l0(o0[3]), .n_lp(o0[2]),
    .n_hlt(o0[1]), .halted(h0), .instr_done(o0[0])
  );

  controlador_sequenciador_param #(
    .T_STATES(8), .OPCODE_W(5), .EARLY_END(0)
  ) dut1 (
    .clk(clk), .clr(clr), .a(a1), .flag_z(fz), .flag_n(fn), .t(t1),
    .cp(o1[14]), .ep(o1[13]), .eu(o1[12]), .su(o1[11]), .ea(o1[10]),
    .n_lm(o1[9]), .n_ce(o1[8]), .n_l1(o1[7]), .n_e1(o1[6]),
    .n_la(o1[5]), .n_lb(o1[4]), .n_l0(o1[3]), .n_lp(o1[2]),
    .n_hlt(o1[1]), .halted(h1), .instr_done(o1[0])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction length in cycles for each instance.
  function automatic int ilen(input int d, input int op);
    if (d == 1) return 8;
    case (op)
      0:       return 5;
      1, 2:    return 6;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] exp_t(input int d);
    if (hlt[d]) return 32'd0;
    return 32'd1 << (step[d] - 1);
  endfunction

  // Expected controls from the micro-op table, {cp..ea, n_*.., n_hlt, done}.
  function automatic logic [14:0] exp_ctl(input int d, input int st,
    input bit h, input int op, input bit z, input bit n);
    bit cp, ep, eu, su, ea, lm, ce, l1, e1, la, lb, l0, lp, hl, dn;
    {cp, ep, eu, su, ea, lm, ce, l1, e1, la, lb, l0, lp, hl, dn} = '0;
    if (h) begin
      hl = 1;
    end else begin
      case (st)
        1: begin ep = 1; lm = 1; end
        2: cp = 1;
        3: begin ce = 1; l1 = 1; end
        4: case (op)
          0, 1, 2: begin lm = 1; e1 = 1; end
          3:       begin e1 = 1; lp = 1; end
          4:       begin e1 = z; lp = z; end
          5:       begin e1 = n; lp = n; end
          14:      begin ea = 1; l0 = 1; end
          15:      hl = 1;
          default: ;
        endcase
        5: case (op)
          0:       begin ce = 1; la = 1; end
          1, 2:    begin ce = 1; lb = 1; end
          default: ;
        endcase
        6: if (op == 1 || op == 2) begin
          eu = 1; la = 1; su = (op == 2);
        end
        default: ;
      endcase
      dn = (st == ilen(d, op)) || (op == 15 && st == 4);
    end
    return {cp, ep, eu, su, ea, ~lm, ~ce, ~l1, ~e1,
            ~la, ~lb, ~l0, ~lp, ~hl, dn};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      step[d] = 1;
      hlt[d]  = 0;
      pick[d] = 1;
    end
  endtask

  task automatic model_edge();
    if (clr) return;
    for (int d = 0; d < 2; d++) begin
      if (!hlt[d]) begin
        if (cur[d] == 15 && step[d] == 4) begin
          hlt[d] = 1;
        end else if (step[d] == ilen(d, cur[d])) begin
          step[d] = 1;
          pick[d] = 1;
        end else begin
          step[d]++;
        end
      end
    end
  endtask

  task automatic drive();
    if (!hlt[0] && pick[0]) begin
      if (q0.size() > 0) cur[0] = q0.pop_front();
      else cur[0] = $urandom_range(0, 14);
      pick[0] = 0;
    end
    if (!hlt[1] && pick[1]) begin
      if (q1.size() > 0) cur[1] = q1.pop_front();
      else begin
        cur[1] = $urandom_range(0, 31);
        if (cur[1] == 15) cur[1] = 16;
      end
      pick[1] = 0;
    end
    a0 = (step[0] < 4) ? 4'($urandom) : 4'(cur[0]);
    a1 = (step[1] < 4) ? 5'($urandom) : 5'(cur[1]);
    fz = (fz_force < 0) ? 1'($urandom) : 1'(fz_force);
    fn = 1'($urandom);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1 drive();
    #1;
  endtask

  task automatic wait_for(input int d, input int op, input int k);
    int n = 0;
    while (!(cur[d] == op && step[d] == k && !hlt[d] && !pick[d])
           && n < 60) begin
      cyc();
      n++;
    end
    if (n >= 60) begin
      tests++;
      fails++;
      $display("FAIL wait d=%0d op=%0d step=%0d timeout", d, op, k);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("t0", t0, exp_t(0));
      chk("halted0", h0, hlt[0]);
      chk("ctl0", o0, exp_ctl(0, step[0], hlt[0], cur[0], fz, fn));
      chk("t1", t1, exp_t(1));
      chk("halted1", h1, hlt[1]);
      chk("ctl1", o1, exp_ctl(1, step[1], hlt[1], cur[1], fz, fn));
    end
  end

  initial begin
    clr = 1'b0;
    cur[0] = 0;
    cur[1] = 0;
    #1 clr = 1'b1;
    model_reset();
    drive();
    #1;
    chk_en = 1'b1;
    chk("rst_t0", t0, 6'b000001);
    chk("rst_t1", t1, 8'h01);
    chk("rst_ctl0", o0, 15'b010000111111110);
    chk("rst_h0", h0, 0);
    cyc();
    clr = 1'b0;

    q0.push_back(1);
    wait_for(0, 1, 5);
    #1 clr = 1'b1;
    model_reset();
    #1;
    chk("midrst_t0", t0, 6'b000001);
    chk("midrst_h0", h0, 0);
    chk("midrst_ep", o0[13], 1);
    chk("midrst_nlm", o0[9], 0);
    clr = 1'b0;
    cyc();
    chk("midrst_next_t0", t0, 6'b000010);

    q0.push_back(0);
    wait_for(0, 0, 5);
    chk("lda_t5", t0, 6'b010000);
    chk("lda_nla", o0[5], 0);
    chk("lda_done", o0[0], 1);
    cyc();
    chk("lda_wrap", t0, 6'b000001);

    q0.push_back(2);
    wait_for(0, 2, 5);
    chk("sub_nlb", o0[4], 0);
    cyc();
    chk("sub_t6", t0, 6'b100000);
    chk("sub_su", o0[11], 1);
    chk("sub_eu", o0[12], 1);
    chk("sub_nla", o0[5], 0);
    cyc();
    chk("sub_wrap", t0, 6'b000001);

    fz_force = 0;
    q0.push_back(4);
    wait_for(0, 4, 4);
    chk("jz0_nlp", o0[2], 1);
    cyc();
    chk("jz0_wrap", t0, 6'b000001);
    fz_force = 1;
    q0.push_back(4);
    wait_for(0, 4, 4);
    chk("jz1_nlp", o0[2], 0);
    chk("jz1_ne1", o0[6], 0);
    cyc();
    chk("jz1_wrap", t0, 6'b000001);
    fz_force = -1;

    q1.push_back(14);
    wait_for(1, 14, 4);
    chk("out8_ea", o1[10], 1);
    chk("out8_nl0", o1[3], 0);
    wait_for(1, 14, 8);
    chk("out8_t8", t1, 8'h80);
    chk("out8_done", o1[0], 1);
    cyc();
    chk("out8_wrap", t1, 8'h01);

    repeat (400) cyc();

    q0.push_back(15);
    wait_for(0, 15, 4);
    chk("hlt_nhlt", o0[1], 0);
    chk("hlt_done", o0[0], 1);
    cyc();
    chk("hlt_t0", t0, 6'b000000);
    chk("hlt_h0", h0, 1);
    repeat (10) cyc();
    chk("hlt_idle_ctl", o0, 15'b000001111111100);
    chk("hlt_idle_t0", t0, 6'b000000);
    clr = 1'b1;
    model_reset();
    #1;
    chk("hlt_clr_t0", t0, 6'b000001);
    chk("hlt_clr_h0", h0, 0);
    cyc();
    clr = 1'b0;
    repeat (200) cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controlador_sequenciador_param.md
# controlador_sequenciador_param

Parametrised controller-sequencer for the SAP CPU. It generalises the fixed six-state decoder into a block that owns its own one-hot T-state ring counter, ends each instruction early once its micro-ops are done, latches HALT, and adds conditional/unconditional jumps driven by accumulator flags. It sits between the instruction register (opcode in) and the datapath (active-high and active-low load/enable lines out).

## Interface
- T_STATES, 6: ring-counter length; legal 6..8. States beyond T6 carry no micro-ops.
- OPCODE_W, 4: opcode width; legal 4..6. Decode compares the full width; listed opcodes are zero-extended.
- EARLY_END, 1: 1 means return to T1 after each instruction's last active state; 0 means always run all T_STATES.
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- a  in  OPCODE_W  opcode from the instruction register; valid from T4 onward.
- flag_z  in  1  accumulator zero flag.
- flag_n  in  1  accumulator negative flag.
- t  out  T_STATES  one-hot T-state; t[0]=T1.
- cp, ep, eu, su, ea  out  1  active-high controls: PC increment, PC enable, ALU enable, subtract, accumulator enable.
- n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0, n_lp  out  1  active-low controls: MAR load, RAM enable, IR load, IR enable, A load, B load, output-register load, PC load.
- n_hlt  out  1  active-low halt indicator.
- halted  out  1  registered halt state.
- instr_done  out  1  high during the final T-state of each instruction.

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, JMP=0011, JZ=0100, JN=0101, OUT=1110, HLT=1111. Any other value is NOP.
- Fetch, common to all opcodes:
  - T1: ep=1, n_lm=0.
  - T2: cp=1.
  - T3: n_ce=0, n_l1=0.
- LDA:
  - T4: n_lm=0, n_e1=0.
  - T5: n_ce=0, n_la=0. Last state is T5.
- ADD and SUB:
  - T4: n_lm=0, n_e1=0.
  - T5: n_ce=0, n_lb=0.
  - T6: eu=1, n_la=0. SUB also asserts su=1 in T6. Last state is T6.
- OUT:
  - T4: ea=1, n_l0=0. Last state is T4.
- JMP:
  - T4: n_e1=0, n_lp=0. Last state is T4.
- JZ and JN:
  - T4: as JMP only when flag_z=1 (JZ) or flag_n=1 (JN), sampled combinationally in T4.
  - Otherwise no micro-ops in T4. Last state is T4 either way.
- NOP: T4 carries no micro-ops. Last state is T4.
- HLT:
  - In T4, n_hlt=0 combinationally.
  - On the edge ending T4, halted is set to 1 and t becomes all zeros.
- Halted state:
  - All t-derived controls are inactive and n_hlt=0.
  - halted stays set until clr; no other exit.
- Ring counter:
  - EARLY_END=1: after an instruction's last state, the next state is T1; otherwise t rotates left.
  - EARLY_END=0: t rotates from T1 through T_STATES and then wraps to T1.
- instr_done:
  - High in the last state as defined above, or in T_STATES when EARLY_END=0.
  - HLT: high in T4.
- Control outputs are combinational from t, a, the flags and halted; only t and halted are registered.

## Timing
- Reset (clr=1, asynchronous):
  - t=1 (T1), halted=0.
  - Outputs therefore read ep=1 and n_lm=0, and all other controls are inactive: n_*=1, cp=eu=su=ea=0, n_hlt=1, instr_done=0.
- Reset takes effect immediately mid-instruction, including while halted. The first rising edge after clr falls moves t to T2.
- Cycles per instruction with EARLY_END=1: LDA 5; ADD and SUB 6; OUT, JMP, JZ, JN and NOP 4. With EARLY_END=0, every instruction takes T_STATES cycles.
- Changes in a or flags during T1–T3 have no effect on the controls.
- A flag change inside T4 of JZ or JN is reflected combinationally.
- No control line is asserted in two different T-states of the same instruction, except where listed above.

## Test plan
- clr pulse mid-T5 of ADD -> t=000001, halted=0, ep=1, n_lm=0 immediately; next edge gives t=000010.
- LDA (a=0000), EARLY_END=1 -> t sequence T1..T5 then T1. n_la=0 only in T5. instr_done high only in T5.
- SUB (a=0010) -> su=eu=1 and n_la=0 only in T6. n_lb=0 only in T5. 6 cycles, then T1.
- JZ with flag_z=0, then with flag_z=1:
  - flag_z=0: n_lp stays 1.
  - flag_z=1: n_lp=0 and n_e1=0 in T4.
  - Both cases return to T1 after 4 cycles.
- HLT (a=1111):
  - n_hlt=0 in T4.
  - After the edge, t=000000 and halted=1.
  - 10 further clocks leave all controls inactive.
  - clr releases to T1.
- EARLY_END=0, T_STATES=8, OUT -> ea=1 and n_l0=0 in T4 only. 8 cycles per instruction. instr_done high in T8.
